// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter that connects N IOb native masters to a single shared slave port.
// A grant is latched once and held until the slave completes the transfer.
module iob_rr_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned GNT_W  = $clog2(N_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state;
  logic [GNT_W-1:0]   r_grant;
  logic [GNT_W-1:0]   r_last;
  logic               r_s_valid;
  logic [ADDR_W-1:0]  r_s_addr;
  logic [DATA_W-1:0]  r_s_wdata;
  logic [STRB_W-1:0]  r_s_wstrb;

  logic               w_found;
  logic [GNT_W-1:0]   w_sel;
  logic [GNT_W-1:0]   w_idx;

  // First requester after the last winner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_idx   = r_last;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      w_idx = GNT_W'((32'(r_last) + k) % N_MASTERS);
      if (!w_found && m_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= GNT_W'(N_MASTERS - 1);
      r_s_valid <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state   <= BUSY;
            r_grant   <= w_sel;
            r_s_valid <= 1'b1;
            r_s_addr  <= m_addr[32'(w_sel)*ADDR_W +: ADDR_W];
            r_s_wdata <= m_wdata[32'(w_sel)*DATA_W +: DATA_W];
            r_s_wstrb <= m_wstrb[32'(w_sel)*STRB_W +: STRB_W];
          end
        end
        BUSY: begin
          // Latched request fields stay put until the slave completes.
          if (s_ready) begin
            r_state   <= IDLE;
            r_last    <= r_grant;
            r_s_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded in the same cycle to the granted master only.
  always_comb begin
    m_ready = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      m_ready[i] = (r_state == BUSY) && s_ready && (r_grant == GNT_W'(i));
    end
  end

  assign m_rdata = {N_MASTERS{s_rdata}};
  assign s_valid = r_s_valid;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_wstrb = r_s_wstrb;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed bench for iob_rr_arbiter with two masters: grant order, stall hold,
// reset abort, spurious ready and dropped-valid cases.
module tb_iob_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_valid;
  logic [31:0] a0, a1, d0, d1;
  logic [3:0]  st0, st1;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;

  int total;
  int bad;

  assign m_addr  = {a1, a0};
  assign m_wdata = {d1, d0};
  assign m_wstrb = {st1, st0};

  iob_rr_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    total = 0; bad = 0;
    rst = 1'b1; m_valid = 2'b00; s_ready = 1'b0; s_rdata = 32'h0;
    a0 = 32'h0; a1 = 32'h0; d0 = 32'h0; d1 = 32'h0; st0 = 4'h0; st1 = 4'h0;
    #1;
    check("rst_s_valid", 64'(s_valid), 64'h0);
    check("rst_s_addr", 64'(s_addr), 64'h0);
    s_ready = 1'b1; #1;
    check("rst_m_ready", 64'(m_ready), 64'h0);
    s_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Single read from master 0.
    m_valid = 2'b01; a0 = 32'h100; st0 = 4'h0;
    tick();
    check("rd_s_valid", 64'(s_valid), 64'h1);
    check("rd_s_addr", 64'(s_addr), 64'h100);
    check("rd_s_wstrb", 64'(s_wstrb), 64'h0);
    check("rd_no_ready", 64'(m_ready), 64'h0);
    m_valid = 2'b00; s_ready = 1'b1; s_rdata = 32'hCAFE; #1;
    check("rd_m_ready", 64'(m_ready), 64'h1);
    check("rd_m_rdata", m_rdata, 64'h0000CAFE_0000CAFE);
    tick();
    s_ready = 1'b0;
    check("rd_idle", 64'(s_valid), 64'h0);

    // Both request: last winner was 0, so grants go 1,0,1,0 with one-cycle gaps.
    m_valid = 2'b11; a0 = 32'h1000; a1 = 32'h2000;
    exp_g = 2'b10;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("rr_s_valid", 64'(s_valid), 64'h1);
      check("rr_s_addr", 64'(s_addr), (exp_g == 2'b10) ? 64'h2000 : 64'h1000);
      s_ready = 1'b1; #1;
      check("rr_m_ready", 64'(m_ready), 64'(exp_g));
      tick();
      s_ready = 1'b0; #1;
      check("rr_gap", 64'(s_valid), 64'h0);
      check("rr_gap_ready", 64'(m_ready), 64'h0);
      exp_g = ~exp_g;
    end

    // Master 1 write held through a 5-cycle stall while master 0 waits.
    m_valid = 2'b10; a1 = 32'h200; d1 = 32'hDEADBEEF; st1 = 4'hF;
    tick();
    m_valid = 2'b01; d1 = 32'h11111111; a1 = 32'h0; st1 = 4'h0;
    for (int n = 0; n < 5; n++) begin
      check("stall_wdata", 64'(s_wdata), 64'hDEADBEEF);
      check("stall_addr", 64'(s_addr), 64'h200);
      check("stall_wstrb", 64'(s_wstrb), 64'hF);
      check("stall_m_ready", 64'(m_ready), 64'h0);
      tick();
    end
    check("stall_s_valid", 64'(s_valid), 64'h1);
    s_ready = 1'b1; #1;
    check("stall_done", 64'(m_ready), 64'h2);
    tick();
    s_ready = 1'b0;
    check("stall_idle", 64'(s_valid), 64'h0);
    tick();
    check("m0_after_stall", 64'(s_addr), 64'h1000);
    check("m0_after_stall_v", 64'(s_valid), 64'h1);

    // Reset while busy drops the transfer; master 0 wins afterwards.
    rst = 1'b1; s_ready = 1'b1; #1;
    check("rst_busy_s_valid", 64'(s_valid), 64'h0);
    check("rst_busy_m_ready", 64'(m_ready), 64'h0);
    check("rst_busy_addr", 64'(s_addr), 64'h0);
    s_ready = 1'b0; m_valid = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_addr", 64'(s_addr), 64'h1000);
    s_ready = 1'b1; #1;
    check("post_rst_m_ready", 64'(m_ready), 64'h1);
    tick();
    s_ready = 1'b0; m_valid = 2'b00;

    // Spurious ready in idle, then master 0 drops valid while granted.
    tick();
    s_ready = 1'b1; #1;
    check("spur_m_ready", 64'(m_ready), 64'h0);
    tick();
    check("spur_s_valid", 64'(s_valid), 64'h0);
    s_ready = 1'b0; m_valid = 2'b01; a0 = 32'h300;
    tick();
    m_valid = 2'b00; a0 = 32'h999;
    tick();
    check("drop_s_valid", 64'(s_valid), 64'h1);
    check("drop_s_addr", 64'(s_addr), 64'h300);
    s_ready = 1'b1; #1;
    check("drop_m_ready", 64'(m_ready), 64'h1);
    tick();
    s_ready = 1'b0;

    // Single persistent requester is granted on every arbitration.
    m_valid = 2'b01; a0 = 32'h400;
    for (int n = 0; n < 2; n++) begin
      tick();
      check("solo_s_valid", 64'(s_valid), 64'h1);
      s_ready = 1'b1; #1;
      check("solo_m_ready", 64'(m_ready), 64'h1);
      tick();
      s_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
